// File: rtl/edabk_param_fifo.sv
// edabk_param_fifo: parametrised first-word-fall-through FIFO for the UART
// TX/RX paths. Circular buffer of 2**ADDRESS_WIDTH entries with an explicit
// occupancy counter, programmable almost-full/almost-empty thresholds and
// sticky overflow/underflow flags.
//
// Optional build macro: EDABK_FIFO_PEAK_LEVEL_EN
//   defined   -> adds output peak_level (maximum level seen since reset,
//                flush or err_clear)
//   undefined -> port and register absent, all other behaviour identical
//
// Default widths come from CFG_DATA_WIDTH / CFG_FIFO_ADDRESS_WIDTH when the
// integration defines them, otherwise 8-bit data and 4 entries.

`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif
`ifndef CFG_FIFO_ADDRESS_WIDTH
`define CFG_FIFO_ADDRESS_WIDTH 2
`endif

module edabk_param_fifo #(
   parameter int DATA_WIDTH    = `CFG_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = `CFG_FIFO_ADDRESS_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     write,
   input  logic                     read,
   input  logic                     flush,
   input  logic                     err_clear,
   input  logic [DATA_WIDTH-1:0]    write_data,
   input  logic [ADDRESS_WIDTH:0]   almost_full_thr,
   input  logic [ADDRESS_WIDTH:0]   almost_empty_thr,
   output logic [DATA_WIDTH-1:0]    read_data,
   output logic [ADDRESS_WIDTH:0]   level,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_full,
   output logic                     almost_empty,
`ifdef EDABK_FIFO_PEAK_LEVEL_EN
   output logic [ADDRESS_WIDTH:0]   peak_level,
`endif
   output logic                     overflow,
   output logic                     underflow
);

   localparam int DEPTH = 1 << ADDRESS_WIDTH;

   // Level value that means "every entry occupied" (MSB set, rest zero).
   localparam logic [ADDRESS_WIDTH:0] LEVEL_FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};

   logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
   logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDRESS_WIDTH:0]   level_q,  level_d;
   logic                     overflow_q,  overflow_d;
   logic                     underflow_q, underflow_d;
   logic                     wr_en, rd_en;

   // Flags are decodes of the registered level, so an accepted push or pop
   // shows on them one cycle after the edge.
   assign empty        = (level_q == '0);
   assign full         = (level_q == LEVEL_FULL);
   assign almost_full  = (level_q >= almost_full_thr);
   assign almost_empty = (level_q <= almost_empty_thr);
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Fall-through head: no read latency, undefined while empty.
   assign read_data = mem_q[rd_ptr_q];

   // Accepts use the registered full/empty, so a read in the same cycle does
   // not make room for a write into a full FIFO. Flush drops both requests.
   assign wr_en = write & ~full  & ~flush;
   assign rd_en = read  & ~empty & ~flush;

   // Next-state for pointers, level and sticky error flags.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

         if (wr_en && !rd_en)      level_d = level_q + 1'b1;
         else if (rd_en && !wr_en) level_d = level_q - 1'b1;

         // A new error in the same cycle as err_clear wins.
         if (err_clear) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
         end
         if (write && full)  overflow_d  = 1'b1;
         if (read  && empty) underflow_d = 1'b1;
      end
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; the level counter already marks every
      // entry invalid, and leaving it out lets the array map to RAM.
      if (wr_en) mem_q[wr_ptr_q] <= write_data;
   end

`ifdef EDABK_FIFO_PEAK_LEVEL_EN
   logic [ADDRESS_WIDTH:0] peak_q, peak_d;

   // Peak tracks the next level; a clear still takes this cycle's level.
   always_comb begin
      peak_d = (flush || err_clear) ? '0 : peak_q;
      if (level_d > peak_d) peak_d = level_d;
   end

   // High-water-mark register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) peak_q <= '0;
      else          peak_q <= peak_d;
   end

   assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_edabk_param_fifo.sv
// Directed self-checking bench for edabk_param_fifo (DATA_WIDTH=8,
// ADDRESS_WIDTH=2). Inputs change 1 ns after the rising edge and outputs are
// compared at that same point, well away from the next edge.

module tb_edabk_param_fifo;

   localparam int DW = 8;
   localparam int AW = 2;

   logic          clk;
   logic          reset_n;
   logic          write;
   logic          read;
   logic          flush;
   logic          err_clear;
   logic [DW-1:0] write_data;
   logic [AW:0]   almost_full_thr;
   logic [AW:0]   almost_empty_thr;
   logic [DW-1:0] read_data;
   logic [AW:0]   level;
   logic          empty;
   logic          full;
   logic          almost_full;
   logic          almost_empty;
   logic          overflow;
   logic          underflow;
`ifdef EDABK_FIFO_PEAK_LEVEL_EN
   logic [AW:0]   peak_level;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   edabk_param_fifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .write            (write),
      .read             (read),
      .flush            (flush),
      .err_clear        (err_clear),
      .write_data       (write_data),
      .almost_full_thr  (almost_full_thr),
      .almost_empty_thr (almost_empty_thr),
      .read_data        (read_data),
      .level            (level),
      .empty            (empty),
      .full             (full),
      .almost_full      (almost_full),
      .almost_empty     (almost_empty),
`ifdef EDABK_FIFO_PEAK_LEVEL_EN
      .peak_level       (peak_level),
`endif
      .overflow         (overflow),
      .underflow        (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; write = 1'b0; read = 1'b0; flush = 1'b0; err_clear = 1'b0;
      write_data = '0; almost_full_thr = '0; almost_empty_thr = '0;
      #12;
      n_checks++;
      if ({level, empty, full, overflow, underflow, almost_empty, almost_full} !== {3'd0, 6'b100011}) begin
         n_fail++;
         $display("FAIL reset_state: got level=%0d e=%b f=%b ov=%b un=%b ae=%b af=%b, want 0 1 0 0 0 1 1",
                  level, empty, full, overflow, underflow, almost_empty, almost_full);
      end
      almost_full_thr = 3'd4;
      #1;
      n_checks++;
      if (almost_full !== 1'b0) begin
         n_fail++; $display("FAIL reset_af_thr4: got %b want 0", almost_full);
      end
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_fill_drain();
      logic [DW-1:0] vals [4];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
      write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         write_data = vals[i];
         cyc();
         n_checks++;
         if (level !== 3'(i + 1) || read_data !== 8'h11 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_%0d: got level=%0d rd=%h empty=%b, want %0d 11 0", i, level, read_data, empty, i + 1);
         end
      end
      write = 1'b0;
      n_checks++;
      if (full !== 1'b1) begin
         n_fail++; $display("FAIL fill_full: got %b want 1", full);
      end
      read = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (read_data !== vals[i]) begin
            n_fail++; $display("FAIL drain_data_%0d: got %h want %h", i, read_data, vals[i]);
         end
         cyc();
      end
      read = 1'b0;
      n_checks++;
      if (empty !== 1'b1 || level !== 3'd0 || full !== 1'b0) begin
         n_fail++; $display("FAIL drain_empty: got empty=%b level=%0d full=%b, want 1 0 0", empty, level, full);
      end
   endtask

   task automatic test_overflow();
      write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         write_data = 8'hA0 + 8'(i);
         cyc();
      end
      write_data = 8'h55;
      cyc();
      write = 1'b0;
      n_checks++;
      if (overflow !== 1'b1 || level !== 3'd4) begin
         n_fail++; $display("FAIL overflow_set: got ov=%b level=%0d, want 1 4", overflow, level);
      end
      cyc(); cyc();
      n_checks++;
      if (overflow !== 1'b1) begin
         n_fail++; $display("FAIL overflow_sticky: got %b want 1", overflow);
      end
      err_clear = 1'b1;
      cyc();
      err_clear = 1'b0;
      n_checks++;
      if (overflow !== 1'b0 || level !== 3'd4) begin
         n_fail++; $display("FAIL overflow_clear: got ov=%b level=%0d, want 0 4", overflow, level);
      end
      read = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (read_data !== 8'hA0 + 8'(i)) begin
            n_fail++; $display("FAIL overflow_contents_%0d: got %h want %h", i, read_data, 8'hA0 + 8'(i));
         end
         cyc();
      end
      read = 1'b0;
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++; $display("FAIL overflow_drained: got empty=%b want 1", empty);
      end
   endtask

   task automatic test_underflow();
      read = 1'b1;
      cyc();
      read = 1'b0;
      n_checks++;
      if (underflow !== 1'b1 || level !== 3'd0 || empty !== 1'b1) begin
         n_fail++; $display("FAIL underflow_set: got un=%b level=%0d empty=%b, want 1 0 1", underflow, level, empty);
      end
      // A pointer moved by the refused read would make the head mismatch.
      write = 1'b1; write_data = 8'h77;
      cyc();
      write = 1'b0;
      n_checks++;
      if (read_data !== 8'h77 || level !== 3'd1 || underflow !== 1'b1) begin
         n_fail++; $display("FAIL underflow_ptrs: got rd=%h level=%0d un=%b, want 77 1 1", read_data, level, underflow);
      end
      // Same-cycle read-on-empty cannot happen now; clear and pop together.
      read = 1'b1; err_clear = 1'b1;
      cyc();
      read = 1'b0; err_clear = 1'b0;
      n_checks++;
      if (underflow !== 1'b0 || empty !== 1'b1) begin
         n_fail++; $display("FAIL underflow_clear: got un=%b empty=%b, want 0 1", underflow, empty);
      end
      // New error in the same cycle as err_clear: set wins.
      read = 1'b1; err_clear = 1'b1;
      cyc();
      read = 1'b0; err_clear = 1'b0;
      n_checks++;
      if (underflow !== 1'b1) begin
         n_fail++; $display("FAIL underflow_set_wins: got %b want 1", underflow);
      end
      err_clear = 1'b1;
      cyc();
      err_clear = 1'b0;
   endtask

   task automatic test_back_to_back();
      write = 1'b1;
      write_data = 8'h80; cyc();
      write_data = 8'h81; cyc();
      read = 1'b1;
      for (int i = 0; i < 10; i++) begin
         write_data = 8'h82 + 8'(i);
         n_checks++;
         if (read_data !== 8'h80 + 8'(i)) begin
            n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", i, read_data, 8'h80 + 8'(i));
         end
         cyc();
         n_checks++;
         if (level !== 3'd2) begin
            n_fail++; $display("FAIL b2b_level_%0d: got %0d want 2", i, level);
         end
      end
      write = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (read_data !== 8'h8A + 8'(i)) begin
            n_fail++; $display("FAIL b2b_tail_%0d: got %h want %h", i, read_data, 8'h8A + 8'(i));
         end
         cyc();
      end
      read = 1'b0;
      n_checks++;
      if (empty !== 1'b1 || underflow !== 1'b0) begin
         n_fail++; $display("FAIL b2b_end: got empty=%b un=%b, want 1 0", empty, underflow);
      end
   endtask

   task automatic test_thresholds();
      logic [1:0] exp_ae [3];
      almost_full_thr = 3'd3; almost_empty_thr = 3'd1;
      // {almost_empty, almost_full} after pushes 1..3
      exp_ae[0] = 2'b10; exp_ae[1] = 2'b00; exp_ae[2] = 2'b01;
      write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         write_data = 8'hC0 + 8'(i);
         cyc();
         n_checks++;
         if ({almost_empty, almost_full} !== exp_ae[i]) begin
            n_fail++; $display("FAIL thr_push_%0d: got ae,af=%b%b want %b", i + 1, almost_empty, almost_full, exp_ae[i]);
         end
      end
      write_data = 8'hC3; cyc();
      write_data = 8'hC4; cyc();   // into full: overflow
      almost_full_thr = 3'd7; almost_empty_thr = 3'd7;
      #1;
      n_checks++;
      if (almost_full !== 1'b0 || almost_empty !== 1'b1 || overflow !== 1'b1) begin
         n_fail++; $display("FAIL thr_above_depth: got af=%b ae=%b ov=%b, want 0 1 1", almost_full, almost_empty, overflow);
      end
      flush = 1'b1; write_data = 8'hEE;
      cyc();
      flush = 1'b0; write = 1'b0;
      n_checks++;
      if (level !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL flush: got level=%0d empty=%b ov=%b, want 0 1 0", level, empty, overflow);
      end
      write = 1'b1; write_data = 8'h99;
      cyc();
      write = 1'b0;
      n_checks++;
      if (read_data !== 8'h99 || level !== 3'd1) begin
         n_fail++; $display("FAIL post_flush: got rd=%h level=%0d, want 99 1", read_data, level);
      end
   endtask

   task automatic test_async_reset();
      write = 1'b1; write_data = 8'h5A;
      cyc();
      write = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (level !== 3'd0 || empty !== 1'b1) begin
         n_fail++; $display("FAIL async_reset: got level=%0d empty=%b, want 0 1", level, empty);
      end
      #3;
      reset_n = 1'b1;
      cyc();
   endtask

`ifdef EDABK_FIFO_PEAK_LEVEL_EN
   task automatic test_peak_level();
      write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         write_data = 8'(i); cyc();
      end
      write = 1'b0; read = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      read = 1'b0;
      n_checks++;
      if (peak_level !== 3'd3 || level !== 3'd0) begin
         n_fail++; $display("FAIL peak_three: got peak=%0d level=%0d want 3 0", peak_level, level);
      end
      err_clear = 1'b1; cyc(); err_clear = 1'b0;
      n_checks++;
      if (peak_level !== 3'd0) begin
         n_fail++; $display("FAIL peak_clear: got %0d want 0", peak_level);
      end
      write = 1'b1; cyc(); write = 1'b0;
      n_checks++;
      if (peak_level !== 3'd1) begin
         n_fail++; $display("FAIL peak_one: got %0d want 1", peak_level);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_thresholds();
      test_async_reset();
`ifdef EDABK_FIFO_PEAK_LEVEL_EN
      test_peak_level();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/edabk_param_fifo.md
Name: edabk_param_fifo

Overview:
Parametrised successor to the single-channel UART I/O FIFO, used on both TX and RX paths of edabk_uart_transceiver.
Circular buffer of 2**ADDRESS_WIDTH entries with first-word-fall-through read data and an explicit occupancy counter.
Adds programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags, so the UART controller can throttle and report errors without polling full/empty every cycle.

Parameters:
DATA_WIDTH, `CFG_DATA_WIDTH, bits per entry
ADDRESS_WIDTH, `CFG_FIFO_ADDRESS_WIDTH, pointer width; DEPTH = 2**ADDRESS_WIDTH entries (ADDRESS_WIDTH >= 1)

Ports:
clk  input  1  clock; all state on rising edge
reset_n  input  1  reset, asynchronous, active-low
write  input  1  write request
read  input  1  read request (pops head)
flush  input  1  synchronous clear of FIFO state
err_clear  input  1  synchronous clear of sticky error flags
write_data  input  DATA_WIDTH  data to push
almost_full_thr  input  ADDRESS_WIDTH+1  almost_full threshold (quasi-static)
almost_empty_thr  input  ADDRESS_WIDTH+1  almost_empty threshold (quasi-static)
read_data  output  DATA_WIDTH  head entry, fall-through
level  output  ADDRESS_WIDTH+1  current occupancy, 0..DEPTH
empty  output  1  level == 0
full  output  1  level == DEPTH
almost_full  output  1  level >= almost_full_thr
almost_empty  output  1  level <= almost_empty_thr
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset values: write_ptr = 0, read_ptr = 0, level = 0. Outputs: empty = 1, full = 0, overflow = 0, underflow = 0; almost_empty = 1; almost_full = (almost_full_thr == 0).
- Memory array is not reset. read_data is undefined while empty.
- Accept rules:
  - wr_en = write & ~full
  - rd_en = read & ~empty
  - Both use registered full/empty; a write is not accepted into a full FIFO even when a read occurs in the same cycle.
- wr_en: mem[write_ptr] <= write_data; write_ptr += 1, wraps DEPTH-1 -> 0 naturally (ADDRESS_WIDTH-bit).
- rd_en: read_ptr += 1 with the same wrap. Memory is not cleared on read.
- level update:
  - +1 on wr_en only
  - -1 on rd_en only
  - unchanged when both or neither
- empty, full, almost_full and almost_empty are combinational decodes of the registered level. They reflect an accepted push/pop one cycle after the edge.
- read_data = mem[read_ptr], combinational. The first written word appears on read_data the cycle after the write (empty deasserts in the same cycle). No read latency.
- overflow set on (write & full); underflow set on (read & empty). Both hold until err_clear, flush or reset. If err_clear and a new error occur in the same cycle, the set wins.
- flush has priority over write/read in the same cycle; both are dropped. Effects: pointers -> 0, level -> 0, overflow/underflow -> 0. Memory contents are retained but unreachable.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous); in-flight data is lost.
- Threshold changes take effect combinationally. Thresholds > DEPTH are legal: almost_full never asserts; almost_empty is always 1.

Optional Feature:
EDABK_FIFO_PEAK_LEVEL_EN
- Defined: adds output peak_level [ADDRESS_WIDTH+1]. It is a register equal to the maximum level observed since reset, flush or err_clear. It updates to next-level when next-level > peak_level. Reset value is 0. err_clear/flush set it to 0, and the same-cycle update still applies after clearing.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Reset, DATA_WIDTH=8, ADDRESS_WIDTH=2: write 0x11,0x22,0x33,0x44 on consecutive cycles -> level 1..4, full=1 after 4th. Read_data=0x11 from cycle after first write. Four reads return 0x11,0x22,0x33,0x44 in order, then empty=1, level=0.
- Full FIFO, write 0x55 -> not stored, overflow=1 and holds. err_clear pulse -> overflow=0, contents unchanged.
- Empty FIFO, read pulse -> underflow=1, level stays 0, pointers unchanged.
- Level=2, write and read in the same cycle, repeated 10 cycles with incrementing data -> level stays 2, pointers wrap, data order preserved.
- almost_full_thr=3, almost_empty_thr=1 -> push 3 words: almost_empty drops after the 2nd, almost_full rises after the 3rd. flush with write asserted -> level=0, empty=1, write dropped.
- With EDABK_FIFO_PEAK_LEVEL_EN defined: push 3, pop 3 -> peak_level=3. err_clear -> 0. Push 1 -> 1.
